// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a frame of up to MAX_OPS operands with AND/OR/XOR/NAND.
// Operands enter on a valid/ready stream; one result leaves on a valid/ready stream.
module logic_reduce_unit #(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned MAX_OPS = 8,
    localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] acc_step_c;
    logic             count_bad_c;

    // Accumulator combined with the operand currently on in_data.
    always_comb begin
        acc_step_c = acc;
        case (op_q)
            OP_OR:   acc_step_c = acc | in_data;
            OP_XOR:  acc_step_c = acc ^ in_data;
            default: acc_step_c = acc & in_data;
        endcase
    end

    // A frame must hold at least one operand and no more than MAX_OPS.
    always_comb begin
        count_bad_c = (count == '0) || (count > MAX_CNT);
    end

    // Frame control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_AND;
            acc       <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_bad_c) begin
                            err <= 1'b1;
                        end else begin
                            op_q      <= op_t'(op_sel);
                            remaining <= count;
                            // AND/NAND start from all-ones, OR/XOR from all-zeros
                            acc       <= (op_sel == OP_AND || op_sel == OP_NAND) ? '1 : '0;
                            state     <= ACCUM;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc       <= acc_step_c;
                        remaining <= remaining - ONE_CNT;
                        if (remaining == ONE_CNT) begin
                            out_data  <= (op_q == OP_NAND) ? ~acc_step_c : acc_step_c;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
